icache_direct: RTL

- Direct-mapped, read-only instruction cache directly upstream of the instruction fetch stage.
- Serves the fetch stage's word requests (ic_req / ic_line_addr / ic_word_select) and returns one 32-bit instruction with a single-cycle ic_ack pulse.
- On a miss it refills a full 64-byte line over the system bus as 8 x 64-bit beats, then answers the pending request.

---
 rtl/icache_direct_if.sv | 35 +++
 rtl/icache_direct.sv | 109 ++++++++++
 2 files changed

// File: rtl/icache_direct_if.sv
// Fetch-side and system-bus-side signals of the direct-mapped instruction cache.
// The slave modport is the cache's view; master is the fetch stage plus the memory system.
interface icache_direct_if #(
    parameter int BUS_TAG_WIDTH = 13
);
    logic                     ic_req;
    logic [57:0]              ic_line_addr;
    logic [3:0]               ic_word_select;
    logic                     ic_flush;
    logic                     ic_ack;
    logic [31:0]              ic_data_out;

    logic                     bus_reqcyc;
    logic [63:0]              bus_req;
    logic [BUS_TAG_WIDTH-1:0] bus_reqtag;
    logic                     bus_reqack;
    logic                     bus_respcyc;
    logic [63:0]              bus_resp;
    logic [BUS_TAG_WIDTH-1:0] bus_resptag;
    logic                     bus_respack;

    modport slave (
        input  ic_req, ic_line_addr, ic_word_select, ic_flush,
        output ic_ack, ic_data_out,
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );

    modport master (
        output ic_req, ic_line_addr, ic_word_select, ic_flush,
        input  ic_ack, ic_data_out,
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: 64-byte lines, refilled as eight
// 64-bit little-endian bus beats, one 32-bit word returned per request.
module icache_direct #(
    parameter int                       BUS_DATA_WIDTH = 64,
    parameter int                       BUS_TAG_WIDTH  = 13,
    parameter int                       NUM_SETS       = 64,
    parameter logic [BUS_TAG_WIDTH-1:0] FILL_TAG       = 13'h1100
) (
    input  logic            clk,
    input  logic            reset,
    icache_direct_if.slave  cif
);

    localparam int         IDX       = $clog2(NUM_SETS);
    localparam int         TAGW      = 58 - IDX;
    localparam int         BEATS     = 512 / BUS_DATA_WIDTH;
    localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, BUSREQ, FILL, RESPOND} state_t;

    state_t              state, state_n;
    logic [NUM_SETS-1:0] valid;
    logic [TAGW-1:0]     tag_mem  [NUM_SETS];
    logic [511:0]        data_mem [NUM_SETS];
    logic [57:0]         req_line;
    logic [3:0]          req_word;
    logic [2:0]          cnt;
    logic [511:0]        line_buf;
    logic [511:0]        full_line;
    logic [31:0]         data_r;
    logic [IDX-1:0]      idx;
    logic                hit;
    logic                beat_ok;
    logic                fill_done;

    function automatic logic [31:0] pick_word(input logic [511:0] line, input logic [3:0] ws);
        logic [63:0] beat;
        beat = line[{ws[3:1], 6'b0} +: 64];
        return ws[0] ? beat[63:32] : beat[31:0];
    endfunction

    assign idx       = req_line[IDX-1:0];
    assign hit       = valid[idx] && (tag_mem[idx] == req_line[57:IDX]);
    assign beat_ok   = (state == FILL) && cif.bus_respcyc && (cif.bus_resptag == FILL_TAG);
    assign fill_done = beat_ok && (cnt == LAST_BEAT);

    // The last beat bypasses line_buf so the line is written in the same cycle it completes.
    always_comb begin
        full_line          = line_buf;
        full_line[511:448] = cif.bus_resp;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (!cif.ic_flush && cif.ic_req) state_n = LOOKUP;
            LOOKUP:  state_n = hit ? RESPOND : BUSREQ;
            BUSREQ:  if (cif.bus_reqack) state_n = FILL;
            FILL:    if (fill_done) state_n = RESPOND;
            RESPOND: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            valid  <= '0;
            cnt    <= '0;
            data_r <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && cif.ic_flush)
                valid <= '0;
            if (state == BUSREQ && cif.bus_reqack)
                cnt <= '0;
            if (beat_ok)
                cnt <= cnt + 3'd1;
            if (state == LOOKUP && hit)
                data_r <= pick_word(data_mem[idx], req_word);
            if (fill_done) begin
                valid[idx] <= 1'b1;
                data_r     <= pick_word(full_line, req_word);
            end
        end
    end

    // Request registers and line storage carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (state == IDLE && !cif.ic_flush && cif.ic_req) begin
            req_line <= cif.ic_line_addr;
            req_word <= cif.ic_word_select;
        end
        if (beat_ok)
            line_buf[{cnt, 6'b0} +: 64] <= cif.bus_resp;
        if (fill_done) begin
            tag_mem[idx]  <= req_line[57:IDX];
            data_mem[idx] <= full_line;
        end
    end

    assign cif.ic_ack      = (state == RESPOND);
    assign cif.ic_data_out = data_r;
    assign cif.bus_reqcyc  = (state == BUSREQ);
    assign cif.bus_req     = (state == BUSREQ) ? {req_line, 6'b0} : 64'd0;
    assign cif.bus_reqtag  = FILL_TAG;
    assign cif.bus_respack = beat_ok;

endmodule
